// File: rtl/cpu_pkg.sv
// Shared CPU encodings: opcodes, ALU and write-back selectors, sequencer states.
// The datapath imports the same constants so both sides agree on every code.
package cpu_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_LDI  = 4'h6;
  localparam logic [3:0] OP_LD   = 4'h7;
  localparam logic [3:0] OP_ST   = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_BZ   = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam logic [2:0] ALU_ADD = 3'd0;
  localparam logic [2:0] ALU_SUB = 3'd1;
  localparam logic [2:0] ALU_AND = 3'd2;
  localparam logic [2:0] ALU_OR  = 3'd3;
  localparam logic [2:0] ALU_XOR = 3'd4;

  localparam logic [1:0] WB_ALU = 2'd0;
  localparam logic [1:0] WB_IMM = 2'd1;
  localparam logic [1:0] WB_MEM = 2'd2;

  function automatic logic op_is_alu(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_XOR);
  endfunction

  // 0xB..0xE are unassigned in the instruction set
  function automatic logic op_is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

  function automatic logic [2:0] alu_code(input logic [3:0] op);
    case (op)
      OP_SUB:  return ALU_SUB;
      OP_AND:  return ALU_AND;
      OP_OR:   return ALU_OR;
      OP_XOR:  return ALU_XOR;
      default: return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/retire_counter.sv
// Free-running retired-instruction counter: increments on i_en, wraps at all-ones.
module retire_counter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_en,
  output logic [DATA_W-1:0] o_count
);

  logic [DATA_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_en) begin
      r_count <= r_count + {{(DATA_W-1){1'b0}}, 1'b1};
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle CPU control FSM: fetch/decode/exec/mem/writeback with a memory
// handshake, plus a retired-instruction counter.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  opcode,
  input  logic        zero_flag,
  input  logic        mem_ready,
  output logic        mem_req,
  output logic        mem_fetch,
  output logic        mem_we,
  output logic        ir_load,
  output logic        pc_inc,
  output logic        pc_load,
  output logic        reg_we,
  output logic [1:0]  wb_sel,
  output logic [2:0]  alu_op,
  output logic        halted,
  output logic        illegal,
  output logic [15:0] retired
);

  state_e     r_state;
  state_e     w_next;
  logic [3:0] r_op;
  logic [3:0] w_op;
  logic       w_retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_FETCH;
      r_op    <= OP_NOP;
    end else begin
      r_state <= w_next;
      if (r_state == ST_DECODE) begin
        r_op <= opcode;
      end
    end
  end

  // In DECODE the latch is being loaded this cycle, so decide on the live input
  assign w_op = (r_state == ST_DECODE) ? opcode : r_op;

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    mem_req   = 1'b0;
    mem_fetch = 1'b0;
    mem_we    = 1'b0;
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    reg_we    = 1'b0;
    wb_sel    = WB_ALU;
    alu_op    = ALU_ADD;
    halted    = 1'b0;
    illegal   = 1'b0;
    if (rst) begin
      // Reset presents an idle fetch request; no handshake completes while held
      mem_req   = 1'b1;
      mem_fetch = 1'b1;
    end else begin
      case (r_state)
        ST_FETCH: begin
          mem_req   = 1'b1;
          mem_fetch = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
            w_next  = ST_DECODE;
          end
        end
        ST_DECODE: begin
          if (w_op == OP_HALT) begin
            w_next = ST_HALT;
          end else if (op_is_illegal(w_op)) begin
            illegal  = 1'b1;
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end else begin
            w_next = ST_EXEC;
          end
        end
        ST_EXEC: begin
          if (op_is_alu(w_op)) begin
            alu_op = alu_code(w_op);
            w_next = ST_WB;
          end else if (w_op == OP_LDI) begin
            w_next = ST_WB;
          end else if ((w_op == OP_LD) || (w_op == OP_ST)) begin
            w_next = ST_MEM;
          end else begin
            pc_load  = (w_op == OP_JMP) || ((w_op == OP_BZ) && zero_flag);
            w_retire = 1'b1;
            w_next   = ST_FETCH;
          end
        end
        ST_MEM: begin
          mem_req = 1'b1;
          mem_we  = (w_op == OP_ST);
          if (mem_ready) begin
            if (w_op == OP_ST) begin
              w_retire = 1'b1;
              w_next   = ST_FETCH;
            end else begin
              w_next = ST_WB;
            end
          end
        end
        ST_WB: begin
          reg_we   = 1'b1;
          w_retire = 1'b1;
          w_next   = ST_FETCH;
          if (op_is_alu(w_op)) begin
            wb_sel = WB_ALU;
          end else if (w_op == OP_LDI) begin
            wb_sel = WB_IMM;
          end else begin
            wb_sel = WB_MEM;
          end
        end
        ST_HALT: begin
          halted = 1'b1;
        end
        default: begin
          w_next = ST_FETCH;
        end
      endcase
    end
  end

  retire_counter #(.DATA_W(16)) u_retire (
    .clk     (clk),
    .rst     (rst),
    .i_en    (w_retire),
    .o_count (retired)
  );

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: per-instruction expected output traces built from
// the instruction timing rules, random waits/opcodes, reset and halt scenarios.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic [3:0]  opcode;
  logic        zero_flag;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_fetch;
  logic        mem_we;
  logic        ir_load;
  logic        pc_inc;
  logic        pc_load;
  logic        reg_we;
  logic [1:0]  wb_sel;
  logic [2:0]  alu_op;
  logic        halted;
  logic        illegal;
  logic [15:0] retired;

  control_sequencer dut (
    .clk       (clk),
    .rst       (rst),
    .opcode    (opcode),
    .zero_flag (zero_flag),
    .mem_ready (mem_ready),
    .mem_req   (mem_req),
    .mem_fetch (mem_fetch),
    .mem_we    (mem_we),
    .ir_load   (ir_load),
    .pc_inc    (pc_inc),
    .pc_load   (pc_load),
    .reg_we    (reg_we),
    .wb_sel    (wb_sel),
    .alu_op    (alu_op),
    .halted    (halted),
    .illegal   (illegal),
    .retired   (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [13:0] B_MREQ = 14'h2000;
  localparam logic [13:0] B_MF   = 14'h1000;
  localparam logic [13:0] B_MWE  = 14'h0800;
  localparam logic [13:0] B_IRL  = 14'h0400;
  localparam logic [13:0] B_PCI  = 14'h0200;
  localparam logic [13:0] B_PCL  = 14'h0100;
  localparam logic [13:0] B_RWE  = 14'h0080;
  localparam logic [13:0] B_HLT  = 14'h0002;
  localparam logic [13:0] B_ILL  = 14'h0001;
  localparam logic [13:0] V_FETCH = B_MREQ | B_MF;

  logic [13:0] obs;
  assign obs = {mem_req, mem_fetch, mem_we, ir_load, pc_inc, pc_load, reg_we,
                wb_sel, alu_op, halted, illegal};

  typedef struct {
    logic [13:0] e;
    logic        rdy;
    logic        dec;
    logic        ex;
  } cyc_t;

  int          checks;
  int          errors;
  logic [15:0] m_retired;

  // Expected trace: fetch (waits + handshake), decode, then exec/mem/wb as the
  // instruction class requires; one expected output word per clock.
  task automatic run_instr(input string name, input logic [3:0] op, input logic zf,
                           input int fw, input int mw);
    cyc_t q[$];
    cyc_t c;
    logic is_alu;
    logic is_ill;
    is_alu = (op >= 4'h1) && (op <= 4'h5);
    is_ill = (op >= 4'hB) && (op <= 4'hE);
    c.dec = 1'b0; c.ex = 1'b0;
    for (int i = 0; i < fw; i++) begin
      c.e = V_FETCH; c.rdy = 1'b0; q.push_back(c);
    end
    c.e = V_FETCH | B_IRL | B_PCI; c.rdy = 1'b1; q.push_back(c);
    c.e = is_ill ? B_ILL : 14'h0; c.rdy = 1'($urandom); c.dec = 1'b1; q.push_back(c);
    c.dec = 1'b0;
    if (!is_ill && op != 4'hF) begin
      c.e = is_alu ? (14'(3'(op - 4'd1)) << 2) : 14'h0;
      if (op == 4'h9 || (op == 4'hA && zf)) c.e = c.e | B_PCL;
      c.rdy = 1'($urandom); c.ex = 1'b1; q.push_back(c);
      c.ex = 1'b0;
      if (op == 4'h7 || op == 4'h8) begin
        for (int i = 0; i <= mw; i++) begin
          c.e = B_MREQ | ((op == 4'h8) ? B_MWE : 14'h0);
          c.rdy = (i == mw);
          q.push_back(c);
        end
      end
      if (is_alu || op == 4'h6 || op == 4'h7) begin
        c.e = B_RWE | ((op == 4'h6) ? (14'd1 << 5) : (op == 4'h7) ? (14'd2 << 5) : 14'h0);
        c.rdy = 1'($urandom); q.push_back(c);
      end
    end
    for (int i = 0; i < q.size(); i++) begin
      @(negedge clk);
      opcode    = q[i].dec ? op : 4'($urandom);
      zero_flag = q[i].ex ? zf : 1'($urandom);
      mem_ready = q[i].rdy;
      #1;
      checks++;
      if (obs !== q[i].e) begin
        errors++;
        $display("FAIL %s op=%h cyc%0d outputs got=%h want=%h", name, op, i, obs, q[i].e);
      end
    end
    if (op != 4'hF) m_retired = m_retired + 16'd1;
    @(posedge clk);
    #1;
    checks++;
    if (retired !== m_retired) begin
      errors++;
      $display("FAIL %s op=%h retired got=%h want=%h", name, op, retired, m_retired);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; mem_ready = 1'b0; opcode = 4'($urandom);
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      errors++;
      $display("FAIL reset_during outputs got=%h want=%h", obs, V_FETCH);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_retired = 16'h0;
    checks++;
    if (obs !== V_FETCH || retired !== 16'h0) begin
      errors++;
      $display("FAIL reset_after outputs got=%h/%h want=%h/0000", obs, retired, V_FETCH);
    end
  endtask

  task automatic test_add();
    run_instr("add", 4'h1, 1'b0, 0, 0);
  endtask

  task automatic test_ld_wait();
    run_instr("ld_wait", 4'h7, 1'b0, 1, 3);
  endtask

  task automatic test_bz();
    run_instr("bz_nz", 4'hA, 1'b0, 0, 0);
    run_instr("bz_z", 4'hA, 1'b1, 2, 0);
  endtask

  task automatic test_illegal();
    run_instr("illegal", 4'hC, 1'b0, 0, 0);
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      run_instr("random", 4'($urandom_range(0, 14)), 1'($urandom),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
  endtask

  task automatic test_wrap();
    @(negedge clk);
    mem_ready = 1'b0;
    force dut.u_retire.r_count = 16'hFFFF;
    @(negedge clk);
    release dut.u_retire.r_count;
    m_retired = 16'hFFFF;
    run_instr("wrap_nop", 4'h0, 1'b0, 0, 0);
  endtask

  task automatic test_reset_mid_mem();
    @(negedge clk); opcode = 4'h8; mem_ready = 1'b1;
    @(negedge clk); opcode = 4'h8; mem_ready = 1'b0;
    @(negedge clk); opcode = 4'h3;
    @(negedge clk); opcode = 4'h1;
    #1;
    checks++;
    if (obs !== (B_MREQ | B_MWE)) begin
      errors++;
      $display("FAIL st_mem outputs got=%h want=%h", obs, B_MREQ | B_MWE);
    end
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== V_FETCH) begin
      errors++;
      $display("FAIL mid_mem_rst_during outputs got=%h want=%h", obs, V_FETCH);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    m_retired = 16'h0;
    checks++;
    if (obs !== V_FETCH || retired !== 16'h0) begin
      errors++;
      $display("FAIL mid_mem_rst_after outputs got=%h/%h want=%h/0000", obs, retired, V_FETCH);
    end
  endtask

  task automatic test_halt();
    run_instr("halt_dec", 4'hF, 1'b0, 1, 0);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      opcode = 4'($urandom); mem_ready = 1'($urandom); zero_flag = 1'($urandom);
      #1;
      checks++;
      if (obs !== B_HLT || retired !== m_retired) begin
        errors++;
        $display("FAIL halt cyc%0d outputs got=%h/%h want=%h/%h", i, obs, retired, B_HLT, m_retired);
      end
    end
  endtask

  initial begin
    checks = 0; errors = 0; m_retired = 16'h0;
    rst = 1'b1; opcode = 4'h0; zero_flag = 1'b0; mem_ready = 1'b0;
    test_reset();
    test_add();
    test_ld_wait();
    test_bz();
    test_illegal();
    test_random();
    test_wrap();
    test_reset_mid_mem();
    run_instr("after_rst", 4'h6, 1'b0, 0, 0);
    test_halt();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
